// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the uart_alu response path.
// UART_RESP_CHECKSUM_EN adds a trailing XOR checksum byte to each response packet.
package uart_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM
    } pkt_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    localparam int          HDR_LEN   = 4;
    localparam logic [7:0]  RSVD_BYTE = 8'h00;

    // Total packet bytes, header included; the length field carries this value.
    function automatic int pkt_len(input int resultwidth);
`ifdef UART_RESP_CHECKSUM_EN
        return HDR_LEN + resultwidth / 8 + 1;
`else
        return HDR_LEN + resultwidth / 8;
`endif
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, data LSB first, stop bit.
// A byte offered during the final stop-bit cycle starts the next frame with no idle gap.
module uart_tx_byte
    import uart_alu_pkg::*;
#(
    parameter int datawidth_p    = 8,
    parameter int clks_per_bit_p = 868
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   byte_valid_i,
    input  logic [datawidth_p-1:0] byte_i,
    output logic                   byte_ready_o,
    output logic                   done_o,
    output logic                   tx_o
);

    localparam int CNTW = (clks_per_bit_p > 1) ? $clog2(clks_per_bit_p) : 1;
    localparam int IDXW = (datawidth_p > 1) ? $clog2(datawidth_p) : 1;

    ser_state_e             state_q;
    logic [CNTW-1:0]        cnt_q;
    logic [IDXW-1:0]        idx_q;
    logic [datawidth_p-1:0] shreg_q;
    logic                   tx_q;

    logic bit_end;
    logic load;

    assign bit_end      = (cnt_q == CNTW'(clks_per_bit_p - 1));
    assign done_o       = (state_q == SER_STOP) && bit_end;
    assign byte_ready_o = (state_q == SER_IDLE) || done_o;
    assign load         = byte_valid_i && byte_ready_o;
    assign tx_o         = tx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else if (load) begin
            state_q <= SER_START;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= byte_i;
            tx_q    <= 1'b0;
        end else begin
            if (state_q != SER_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            if (bit_end) begin
                case (state_q)
                    SER_START: begin
                        state_q <= SER_DATA;
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                    SER_DATA: begin
                        if (idx_q == IDXW'(datawidth_p - 1)) begin
                            state_q <= SER_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
                    SER_STOP: begin
                        state_q <= SER_IDLE;
                        tx_q    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Response packetizer: opcode, reserved, length LSB/MSB, result bytes LSB first, out over 8N1 UART.
// UART_RESP_CHECKSUM_EN appends the XOR of all preceding bytes and counts it in the length.
module uart_resp_tx
    import uart_alu_pkg::*;
#(
    parameter int datawidth_p    = 8,
    parameter int clks_per_bit_p = 868,
    parameter int resultwidth_p  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     res_valid_i,
    output logic                     res_ready_o,
    input  logic [7:0]               res_opcode_i,
    input  logic [resultwidth_p-1:0] res_data_i,
    output logic                     tx_o,
    output logic                     busy_o
);

    localparam int NB   = resultwidth_p / 8;
    localparam int LEN  = pkt_len(resultwidth_p);
    localparam int IDXW = $clog2(LEN + 1);

    pkt_state_e               state_q;
    logic [IDXW-1:0]          idx_q;
    logic [7:0]               opcode_q;
    logic [resultwidth_p-1:0] data_q;
    logic                     ready_q;
    logic                     busy_q;

    logic [7:0] pkt_bytes [LEN];
    logic [7:0] cur_byte;
    logic [7:0] ser_byte;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_done;
    logic       load;

    assign pkt_bytes[0] = opcode_q;
    assign pkt_bytes[1] = RSVD_BYTE;
    assign pkt_bytes[2] = 8'(LEN);
    assign pkt_bytes[3] = 8'(LEN >> 8);

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_data_bytes
            assign pkt_bytes[HDR_LEN + gi] = data_q[8*gi +: 8];
        end
    endgenerate

`ifdef UART_RESP_CHECKSUM_EN
    logic [7:0] csum_q;
    assign pkt_bytes[LEN-1] = csum_q;
`endif

    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < LEN; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_byte = pkt_bytes[i];
            end
        end
    end

    // Byte 0 comes straight from the inputs so the start bit follows the transfer edge.
    assign ser_byte  = (state_q == ST_IDLE) ? res_opcode_i : cur_byte;
    assign ser_valid = (state_q == ST_IDLE) ? (res_valid_i && ready_q)
                                            : (idx_q < IDXW'(LEN));
    assign load      = ser_valid && ser_ready;

    uart_tx_byte #(
        .datawidth_p    (datawidth_p),
        .clks_per_bit_p (clks_per_bit_p)
    ) u_tx_byte (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (ser_valid),
        .byte_i       (ser_byte),
        .byte_ready_o (ser_ready),
        .done_o       (ser_done),
        .tx_o         (tx_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            opcode_q <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else if (state_q == ST_IDLE) begin
            if (load) begin
                state_q  <= ST_HDR;
                idx_q    <= IDXW'(1);
                opcode_q <= res_opcode_i;
                data_q   <= res_data_i;
                ready_q  <= 1'b0;
                busy_q   <= 1'b1;
`ifdef UART_RESP_CHECKSUM_EN
                csum_q   <= res_opcode_i;
`endif
            end else begin
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end else if (load) begin
            // State names the class of byte now on the wire.
            idx_q <= idx_q + 1'b1;
            if (idx_q < IDXW'(HDR_LEN)) begin
                state_q <= ST_HDR;
            end else if (idx_q < IDXW'(HDR_LEN + NB)) begin
                state_q <= ST_DATA;
            end else begin
                state_q <= ST_CSUM;
            end
`ifdef UART_RESP_CHECKSUM_EN
            csum_q <= csum_q ^ cur_byte;
`endif
        end else if (ser_done) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end
    end

    assign res_ready_o = ready_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// Directed bench for uart_resp_tx at 4 clocks per bit; decodes tx_o cycle by cycle.
module tb_uart_resp_tx;

    localparam int CPB   = 4;
    localparam int RW    = 32;
    localparam int FRAME = 10 * CPB;
`ifdef UART_RESP_CHECKSUM_EN
    localparam int PLEN = 9;
`else
    localparam int PLEN = 8;
`endif
    localparam int PCYC = FRAME * PLEN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          res_valid = 1'b0;
    logic [7:0]    res_opcode = 8'h00;
    logic [RW-1:0] res_data = '0;
    logic          res_ready;
    logic          tx;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic       bits [PCYC];
    logic [7:0] exp_bytes [PLEN];

    uart_resp_tx #(
        .datawidth_p    (8),
        .clks_per_bit_p (CPB),
        .resultwidth_p  (RW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .res_valid_i  (res_valid),
        .res_ready_o  (res_ready),
        .res_opcode_i (res_opcode),
        .res_data_i   (res_data),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic build_exp(input logic [7:0] op, input logic [31:0] data);
        exp_bytes[0] = op;
        exp_bytes[1] = 8'h00;
        exp_bytes[2] = 8'(PLEN);
        exp_bytes[3] = 8'h00;
        for (int i = 0; i < 4; i++) exp_bytes[4+i] = data[8*i +: 8];
`ifdef UART_RESP_CHECKSUM_EN
        exp_bytes[8] = 8'h00;
        for (int i = 0; i < 8; i++) exp_bytes[8] = exp_bytes[8] ^ exp_bytes[i];
`endif
    endtask

    // Present a result and wait (bounded) for the transfer edge; inputs are scrambled afterwards.
    task automatic send(input logic [7:0] op, input logic [31:0] data);
        int t;
        @(negedge clk);
        res_valid  = 1'b1;
        res_opcode = op;
        res_data   = data;
        t = 0;
        while (res_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq("hs_ready", 32'(res_ready), 32'd1);
        @(posedge clk);
        #1;
        res_valid  = 1'b0;
        res_opcode = 8'hEE;
        res_data   = 32'hCAFEF00D;
    endtask

    // Sample one packet's worth of cycles; optionally inject a rejected valid or abort with reset.
    task automatic capture(input int inj_at, input int rst_at);
        int viol;
        viol = 0;
        for (int k = 0; k < PCYC; k++) begin
            @(negedge clk);
            bits[k] = tx;
            if (busy !== 1'b1 || res_ready !== 1'b0) viol++;
            if (k == inj_at) begin
                res_valid  = 1'b1;
                res_opcode = 8'h99;
                res_data   = 32'hDEADBEEF;
            end
            if (k == inj_at + 1) res_valid = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        check_eq("busy_window", 32'(viol), 32'd0);
    endtask

    task automatic after_packet();
        @(negedge clk);
        check_eq("ready_return", 32'(res_ready), 32'd1);
        check_eq("busy_clear", 32'(busy), 32'd0);
        check_eq("tx_idle", 32'(tx), 32'd1);
    endtask

    task automatic check_packet(input string name);
        for (int f = 0; f < PLEN; f++) begin
            logic [7:0] b;
            logic       ok;
            ok = 1'b1;
            b  = '0;
            for (int j = 0; j < 10; j++) begin
                int base;
                base = f * FRAME + j * CPB;
                for (int c = 1; c < CPB; c++) if (bits[base+c] !== bits[base]) ok = 1'b0;
                if (j == 0 && bits[base] !== 1'b0) ok = 1'b0;
                if (j == 9 && bits[base] !== 1'b1) ok = 1'b0;
                if (j >= 1 && j <= 8) b[j-1] = bits[base];
            end
            check_eq($sformatf("%s_byte%0d", name, f), 32'(b), 32'(exp_bytes[f]));
            check_eq($sformatf("%s_frame%0d", name, f), 32'(ok), 32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle_bad;
        logic [9:0] pat;

        // Reset held three cycles.
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(res_ready), 32'd0);
        @(negedge clk);
        check_eq("rst_ready_hold", 32'(res_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_ready", 32'(res_ready), 32'd1);
        check_eq("rel_tx", 32'(tx), 32'd1);
        check_eq("rel_busy", 32'(busy), 32'd0);

        // Basic packet.
        build_exp(8'h10, 32'h12345678);
        send(8'h10, 32'h12345678);
        capture(-10, -10);
        after_packet();
        check_packet("basic");
`ifdef UART_RESP_CHECKSUM_EN
        check_eq("basic_csum_const", 32'(exp_bytes[8]), 32'h11);
`endif

        // Exact bit timing of byte 4 for data 0xA5.
        build_exp(8'h3C, 32'h000000A5);
        send(8'h3C, 32'h000000A5);
        capture(-10, -10);
        after_packet();
        check_packet("a5");
        pat = 10'b1101001010;
        for (int j = 0; j < 10; j++) begin
            logic [3:0] lv;
            for (int c = 0; c < CPB; c++) lv[c] = bits[4*FRAME + j*CPB + c];
            check_eq($sformatf("a5_bit%0d", j), 32'(lv), 32'({4{pat[j]}}));
        end
        check_eq("a5_gap_stop", 32'(bits[4*FRAME-1]), 32'd1);
        check_eq("a5_gap_start", 32'(bits[4*FRAME]), 32'd0);

        // Second valid mid-packet is ignored.
        build_exp(8'h20, 32'h0BADF00D);
        send(8'h20, 32'h0BADF00D);
        capture(150, -10);
        after_packet();
        check_packet("busy");
        idle_bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check_eq("busy_no_queue", 32'(idle_bad), 32'd0);

        // Reset during byte 2, then a clean packet.
        send(8'h22, 32'h55AA55AA);
        capture(-10, 2*FRAME + 15);
        @(negedge clk);
        check_eq("mid_rst_tx", 32'(tx), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(res_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rel_ready", 32'(res_ready), 32'd1);
        build_exp(8'h11, 32'h00000001);
        send(8'h11, 32'h00000001);
        capture(-10, -10);
        after_packet();
        check_packet("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_resp_tx.md
Name: uart_resp_tx

Overview:
- Transmit-side counterpart of the command receiver in uart_alu.
- Accepts one 32-bit ALU result plus its opcode on a valid/ready handshake and frames it into a response packet.
- Serializes the packet onto the board TX pin as 8N1 UART, LSB first.
- Sits between the ALU datapath and the tx_o pin in the uart_alu top.

Parameters:
- datawidth_p, 8, UART character width in bits; packet logic requires 8.
- clks_per_bit_p, 868, clk_i cycles per UART bit (100 MHz / 115200 baud).
- resultwidth_p, 32, result width; must be a multiple of 8; number of data bytes = resultwidth_p/8.

Ports:
- clk_i  input  1  system clock (100 MHz PLL output)
- rst_i  input  1  synchronous, active-high reset
- res_valid_i  input  1  result/opcode valid
- res_ready_o  output  1  block can accept a result
- res_opcode_i  input  8  opcode of the command being answered
- res_data_i  input  resultwidth_p  ALU result
- tx_o  output  1  UART serial out; idle high
- busy_o  output  1  packet in flight

Behaviour:
- Reset (rst_i sampled high at a clk_i edge):
  - tx_o=1, res_ready_o=0 during reset, busy_o=0.
  - FSM to IDLE; all counters cleared.
  - Reset mid-packet aborts immediately: tx_o=1 on the following cycle; no partial-byte completion.
- Handshake: res_ready_o=1 only in IDLE and not in reset. Transfer occurs when valid&ready. Opcode and data are captured into registers, so inputs may change after the transfer.
- Packet byte order:
  - Byte 0: opcode echo.
  - Byte 1: 0x00 reserved.
  - Byte 2: length LSB.
  - Byte 3: length MSB.
  - Then the data bytes, least-significant byte first.
  - Length = total packet bytes including header: 4 + resultwidth_p/8, which is 8 by default.
- Packer FSM:
  - IDLE -> HDR (on transfer).
  - HDR -> DATA after byte 3.
  - DATA -> IDLE after the last data byte's stop bit.
  - Each state presents one byte to the serializer and advances on the serializer's done pulse.
- Serializer:
  - Frame: start bit (0), datawidth_p data bits LSB first, stop bit (1); each bit held exactly clks_per_bit_p cycles.
  - Bit timer counts 0..clks_per_bit_p-1 and wraps.
  - Back-to-back bytes: the next start bit begins on the cycle after the previous stop bit's final cycle, with no idle gap inside a packet.
- Latency: transfer at cycle N -> tx_o falls at N+1 -> whole packet lasts exactly 10*clks_per_bit_p*len cycles.
- Return to IDLE: res_ready_o rises on the cycle after the last stop bit ends.
- busy_o: high from N+1 through the last stop-bit cycle, in step with ~res_ready_o outside reset.
- res_valid_i asserted while busy is ignored, with no queueing; the producer must hold valid until ready.

Optional Feature:
- Macro: UART_RESP_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent, equal to the XOR of all preceding packet bytes. The length field counts this byte (9 by default).
- Undefined: no checksum byte, length = 4 + resultwidth_p/8, and no checksum logic is synthesized.

Decomposition:
- Shared package uart_alu_pkg holds:
  - FSM state enum (IDLE, HDR, DATA, CSUM).
  - Reserved-byte constant 0x00.
  - Header length constant (4).
  - Function computing packet length from resultwidth_p.
- One natural sub-module: uart_tx_byte, the 8N1 serializer with byte valid/ready in and a done pulse out. uart_resp_tx instantiates one.

Test Plan:
- Reset idle: set clks_per_bit_p=4 and hold rst_i for 3 cycles -> tx_o=1, busy_o=0, res_ready_o=0 during reset and 1 on the cycle after release.
- Basic packet: opcode 0x10, data 0x12345678 -> decoded bytes 10 00 08 00 78 56 34 12. Frames are 40 cycles each; the total is 320 cycles. res_ready_o returns at cycle N+321.
- Bit timing: send data 0x000000A5 with clks_per_bit_p=4 -> tx_o for byte 4 is 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles, with no gap between frames.
- Busy rejection: pulse a second valid with data 0xDEADBEEF mid-packet -> ignored; only the first packet appears; res_ready_o stays 0.
- Reset mid-packet: assert rst_i during byte 2 -> tx_o=1 next cycle; after release, a new packet with opcode 0x11 and data 0x1 transmits correctly from byte 0.
- UART_RESP_CHECKSUM_EN defined: opcode 0x10, data 0x12345678 -> bytes 10 00 09 00 78 56 34 12 followed by the XOR of those 8 bytes. Total 360 cycles.
